// File: rtl/uart_cmd_tx.sv
// UART transmit engine fed by the 7-bit command bus: nibble-loaded holding register,
// programmable bit prescaler, optional parity and 1/2 stop bits, status byte on io_out8.
module uart_cmd_tx #(
    parameter logic [7:0] PREDIV_RESET = 8'd15,
    parameter logic [3:0] CONFIG_RESET = 4'b0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] io_in7,
    input  logic       io_cmdValid,
    output logic       io_txd,
    output logic [7:0] io_out8,
    output logic       io_resetCommandStrobe,
    output logic       io_gatedTxdStopBitSupport
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } state_t;

    localparam logic [1:0] CMD_DATA   = 2'd0;
    localparam logic [1:0] CMD_CONFIG = 2'd1;
    localparam logic [1:0] CMD_PREDIV = 2'd2;
    localparam logic [1:0] CMD_SPARE  = 2'd3;

    logic [1:0] cmd;
    logic [4:0] payload;
    assign cmd     = io_in7[1:0];
    assign payload = io_in7[6:2];

    state_t     state, state_nxt;
    logic [7:0] hold, shifter, prediv, frame_prediv, cnt;
    logic [3:0] cfg, frame_cfg;
    logic [2:0] bit_idx;
    logic       hold_full, overrun, frame_par, strobe;
    logic       soft_rst, data_wr, cfg_wr, pre_wr, ovr_clr, load, bit_end;

    assign soft_rst = io_cmdValid && (cmd == CMD_CONFIG) && (payload == 5'b11000);
    assign cfg_wr   = io_cmdValid && (cmd == CMD_CONFIG) && !payload[4];
    assign data_wr  = io_cmdValid && (cmd == CMD_DATA);
    assign pre_wr   = io_cmdValid && (cmd == CMD_PREDIV);
    assign ovr_clr  = io_cmdValid && (cmd == CMD_SPARE) && (payload == 5'd0);
    assign bit_end  = (state != ST_IDLE) && (cnt == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            ST_IDLE:   if (hold_full) begin
                           state_nxt = ST_START;
                           load      = 1'b1;
                       end
            ST_START:  if (bit_end) state_nxt = ST_DATA;
            ST_DATA:   if (bit_end && bit_idx == 3'd7)
                           state_nxt = frame_cfg[1] ? ST_PARITY : ST_STOP1;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP1;
            ST_STOP1:  if (bit_end) state_nxt = frame_cfg[0] ? ST_STOP2 : ST_IDLE;
            ST_STOP2:  if (bit_end) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        // Soft reset aborts everything, including a transfer out of IDLE in the same cycle
        if (soft_rst) begin
            state_nxt = ST_IDLE;
            load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold         <= 8'd0;
            hold_full    <= 1'b0;
            overrun      <= 1'b0;
            shifter      <= 8'd0;
            cnt          <= 8'd0;
            bit_idx      <= 3'd0;
            frame_par    <= 1'b0;
            prediv       <= PREDIV_RESET;
            frame_prediv <= PREDIV_RESET;
            cfg          <= CONFIG_RESET;
            frame_cfg    <= CONFIG_RESET;
            strobe       <= 1'b0;
        end else if (soft_rst) begin
            hold         <= 8'd0;
            hold_full    <= 1'b0;
            overrun      <= 1'b0;
            shifter      <= 8'd0;
            cnt          <= 8'd0;
            bit_idx      <= 3'd0;
            frame_par    <= 1'b0;
            prediv       <= PREDIV_RESET;
            frame_prediv <= PREDIV_RESET;
            cfg          <= CONFIG_RESET;
            frame_cfg    <= CONFIG_RESET;
            strobe       <= 1'b1;
        end else begin
            strobe <= 1'b0;

            if (load) begin
                shifter      <= hold;
                frame_cfg    <= cfg;
                frame_prediv <= prediv;
                frame_par    <= (^hold) ^ cfg[2];
                bit_idx      <= 3'd0;
                cnt          <= prediv;
            end else if (bit_end) begin
                cnt <= frame_prediv;
                if (state == ST_DATA) begin
                    shifter <= shifter >> 1;
                    bit_idx <= bit_idx + 3'd1;
                end
            end else if (state != ST_IDLE) begin
                cnt <= cnt - 8'd1;
            end

            // A hi-nibble write in the load cycle refills hold; its set wins over the clear
            if (load) hold_full <= 1'b0;
            if (data_wr) begin
                if (hold_full && !load) begin
                    overrun <= 1'b1;
                end else if (payload[4]) begin
                    hold[7:4] <= payload[3:0];
                    hold_full <= 1'b1;
                end else begin
                    hold[3:0] <= payload[3:0];
                end
            end
            if (ovr_clr) overrun <= 1'b0;

            if (cfg_wr) cfg <= payload[3:0];
            if (pre_wr) begin
                if (payload[4]) prediv[7:4] <= payload[3:0];
                else            prediv[3:0] <= payload[3:0];
            end
        end
    end

    always_comb begin
        case (state)
            ST_START:  io_txd = 1'b0;
            ST_DATA:   io_txd = shifter[0];
            ST_PARITY: io_txd = frame_par;
            default:   io_txd = 1'b1;
        endcase
    end

    assign io_out8 = {(state != ST_IDLE), hold_full, overrun, io_txd, 1'b0, state};
    assign io_resetCommandStrobe = strobe;
    assign io_gatedTxdStopBitSupport = frame_cfg[3] &&
                                       ((state == ST_STOP1) || (state == ST_STOP2));

endmodule

// File: doc/uart_cmd_tx.md
Name: uart_cmd_tx

Overview:
UART transmit engine driven by the same 7-bit command bus the UART core decodes: cmd[1:0] selects DATA/CONFIG/PREDIV/SPARE and payload[4:0] carries data.
- Bytes are loaded as two nibbles into a one-deep holding register, then serialised LSB-first on txd.
- Frame format: start, 8 data bits, optional parity, 1 or 2 stop bits.
- Bit timing comes from a programmable prescaler.
- Sits between the TT pin wrapper and the txd pin; exposes a status byte on io_out8.

Parameters:
PREDIV_RESET, 8'd15, prescaler value after reset and after soft reset (bit period = PREDIV+1 clocks)
CONFIG_RESET, 4'b0000, config register value after reset and after soft reset

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous, active-low reset
io_in7  in  7  [1:0]=cmd (0 DATA, 1 CONFIG, 2 PREDIV, 3 SPARE); [6:2]=payload[4:0]
io_cmdValid  in  1  command on io_in7 executed in every cycle this is 1
io_txd  out  1  serial output, idle high
io_out8  out  8  status {busy, hold_full, overrun, txd, 1'b0, state[2:0]}
io_resetCommandStrobe  out  1  one-cycle pulse when soft reset executes
io_gatedTxdStopBitSupport  out  1  high during STOP1/STOP2 when config[3]=1

Behaviour:
- Reset (rst_n=0, async):
  - io_txd=1; state=IDLE; hold, hold_full, overrun=0.
  - prediv=PREDIV_RESET; config=CONFIG_RESET.
  - io_resetCommandStrobe=0; io_gatedTxdStopBitSupport=0.
- Commands (io_cmdValid=1 only):
  - DATA, payload[4]=0: hold[3:0]<=payload[3:0].
  - DATA, payload[4]=1: hold[7:4]<=payload[3:0]; hold_full<=1.
  - DATA while hold_full=1 and no IDLE->START transfer in the same cycle: write dropped; overrun<=1.
  - CONFIG, payload=5'b11000: soft reset. All registers take their reset values, any frame in flight is aborted, txd=1 next cycle, io_resetCommandStrobe=1 for exactly the next cycle.
  - CONFIG, payload[4]=0: config<=payload[3:0]. config[0]=two stop bits; [1]=parity enable; [2]=odd parity; [3]=stop-gating output enable.
  - CONFIG, other payloads: ignored.
  - PREDIV, payload[4]=0: prediv[3:0]<=payload[3:0]. payload[4]=1: prediv[7:4]<=payload[3:0].
  - SPARE, payload=0: overrun<=0. Other payloads ignored.
- FSM states, encoding on status[2:0]: IDLE=0, START=1, DATA=2, PARITY=3, STOP1=4, STOP2=5.
  - IDLE with hold_full=1: shifter<=hold; hold_full<=0; latch config and prediv into frame copies; go to START. txd goes low on the next cycle.
  - Each non-IDLE state lasts exactly frame_prediv+1 clocks, counted by an 8-bit down-counter reloaded on entry.
  - START: txd=0.
  - DATA: txd=shifter[0]; shift right at the end of each bit; 8 bits, bit index 0..7.
  - PARITY: entered only if parity enable. txd = XOR(data), inverted when odd parity is selected.
  - STOP1 (txd=1), then STOP2 if two stop bits selected, then IDLE.
  - A byte already in hold is accepted at the STOP->IDLE boundary and leaves IDLE on the following cycle: one idle cycle between frames.
- busy=1 in any non-IDLE state.
- Mid-frame CONFIG/PREDIV writes affect only the next frame.
- prediv=0 gives a 1-clock bit period.
- Mid-frame soft reset or rst_n: txd forced to 1, no partial stop bits.

Test Plan:
- Reset, prediv=8'h03, config=0, DATA 0x5 (lo) then 0x3 (hi) -> txd low 1 cycle after hold_full; 40-clock frame 0,1,0,1,0,1,1,0,0,1 (LSB first, 0x35); busy falls after 40 clocks.
- config=4'b0011 (even parity, 2 stop), byte 0x07, prediv=1 -> frame start, 1,1,1,0,0,0,0,0, parity 1, stop 1,1; 24 clocks total.
- Queue 0xA5, then queue 0x3C while first frame busy, then a third hi-nibble write -> 0x3C sent after one idle cycle; overrun=1 on status bit 5; SPARE payload 0 clears it.
- CONFIG payload 5'b11000 during DATA bit 3 -> io_resetCommandStrobe high exactly one cycle; txd=1; prediv reads back 8'h0F in timing; state=0.
- config[3]=1 with 2 stop bits -> io_gatedTxdStopBitSupport high for exactly 2*(prediv+1) clocks per frame.
- Assert rst_n low mid-frame (asynchronous to clk) -> txd=1 and io_out8=8'h10 immediately, before the next clock edge.
